// File: rtl/dual_port_arbitrated_onchip_ram.sv
// rtl/dual_port_arbitrated_onchip_ram.sv - two Avalon-MM slave ports round-robin arbitrated onto one single-port RAM
module dual_port_arbitrated_onchip_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 14,
    parameter int    DEPTH      = 10024,
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = "onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {PORT_S1 = 1'b0, PORT_S2 = 1'b1} port_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en, req1, req2, grant1, grant2;
    port_e                 last_q, last_d, sel_port;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_read, acc_write, acc_go, acc_wr, acc_rd, in_range;
    logic [BE_W-1:0]       acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata, rd_word;

    logic                  ret_valid;
    port_e                 ret_port;
    logic [DATA_WIDTH-1:0] ret_data;
    logic                  rdv1_q, rdv2_q;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata2_q;

    assign en   = clken & ~reset_req;
    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // On contention the port that was not served last wins.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (en) begin
            if (req1 && (!req2 || last_q == PORT_S2)) grant1 = 1'b1;
            else if (req2)                            grant2 = 1'b1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant1)      last_d = PORT_S1;
        else if (grant2) last_d = PORT_S2;
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    assign sel_port  = grant2 ? PORT_S2 : PORT_S1;
    assign acc_addr  = grant2 ? s2_address    : s1_address;
    assign acc_read  = grant2 ? s2_read       : s1_read;
    assign acc_write = grant2 ? s2_write      : s1_write;
    assign acc_be    = grant2 ? s2_byteenable : s1_byteenable;
    assign acc_wdata = grant2 ? s2_writedata  : s1_writedata;

    // Reset suppresses the access entirely so nothing is written or returned.
    assign acc_go   = (grant1 | grant2) & ~reset;
    assign acc_wr   = acc_go & acc_write;
    assign acc_rd   = acc_go & acc_read & ~acc_write;
    assign in_range = {1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH);

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem[acc_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (acc_wr && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) mem[acc_addr[IDX_W-1:0]][i*8 +: 8] <= acc_wdata[i*8 +: 8];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  p_valid_q;
            port_e                 p_port_q;
            logic [DATA_WIDTH-1:0] p_data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    p_valid_q <= 1'b0;
                    p_port_q  <= PORT_S1;
                    p_data_q  <= '0;
                end else if (en) begin
                    p_valid_q <= acc_rd;
                    p_port_q  <= sel_port;
                    p_data_q  <= rd_word;
                end
            end

            assign ret_valid = p_valid_q;
            assign ret_port  = p_port_q;
            assign ret_data  = p_data_q;
        end else begin : g_no_out_reg
            assign ret_valid = acc_rd;
            assign ret_port  = sel_port;
            assign ret_data  = rd_word;
        end
    endgenerate

    // Per-port return registers keep readdata stable between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= PORT_S2;
            rdv1_q   <= 1'b0;
            rdv2_q   <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else if (en) begin
            last_q <= last_d;
            rdv1_q <= ret_valid && ret_port == PORT_S1;
            rdv2_q <= ret_valid && ret_port == PORT_S2;
            if (ret_valid && ret_port == PORT_S1) rdata1_q <= ret_data;
            if (ret_valid && ret_port == PORT_S2) rdata2_q <= ret_data;
        end
    end

    assign s1_readdatavalid = rdv1_q & en;
    assign s2_readdatavalid = rdv2_q & en;
    assign s1_readdata      = rdata1_q;
    assign s2_readdata      = rdata2_q;

endmodule

// File: tb/tb_dual_port_arbitrated_onchip_ram.sv
// tb/tb_dual_port_arbitrated_onchip_ram.sv - scoreboard bench for dual_port_arbitrated_onchip_ram (OUT_REG 0 and 1)
module tb_dual_port_arbitrated_onchip_ram;
    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
    logic [13:0] s1_address = '0, s2_address = '0;
    logic        s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic        s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic        rdv1 [2];
    logic        rdv2 [2];
    logic        wait1 [2];
    logic        wait2 [2];

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dual_port_arbitrated_onchip_ram #(
            .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(10024), .OUT_REG(g), .INIT_FILE("onchip_ram.hex")
        ) dut (
            .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
            .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
            .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
            .s1_readdata(rdata1[g]), .s1_readdatavalid(rdv1[g]), .s1_waitrequest(wait1[g]),
            .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
            .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
            .s2_readdata(rdata2[g]), .s2_readdatavalid(rdv2[g]), .s2_waitrequest(wait2[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic rd, input logic wr, input logic [13:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 1) begin
            s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
            s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
            s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
    endtask

    task automatic clear(input int p);
        if (p == 1) begin s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; end
        else        begin s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0; end
    endtask

    // port: 0 = s1, 1 = s2; due cycles given per OUT_REG variant
    task automatic push(input logic port, input logic [31:0] data, input int due0, input int due1,
                        input bit use0, input bit use1);
        exp_t e;
        e.port = port; e.data = data;
        if (use0) begin e.due = due0; q[0].push_back(e); end
        if (use1) begin e.due = due1; q[1].push_back(e); end
    endtask

    task automatic take(input int d, input logic port, input logic [31:0] data);
        exp_t e;
        if (q[d].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_return dut%0d: got port %0d data %h expected no return", d, port, data);
        end else begin
            e = q[d].pop_front();
            chk($sformatf("ret_port_dut%0d", d), {31'd0, port}, {31'd0, e.port});
            chk($sformatf("ret_data_dut%0d", d), data, e.data);
            chk($sformatf("ret_cycle_dut%0d", d), cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdv1[d] === 1'b1) take(d, 1'b0, rdata1[d]);
            if (rdv2[d] === 1'b1) take(d, 1'b1, rdata2[d]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdv1", rdv1[d], 0);
            chk("rst_rdv2", rdv2[d], 0);
            chk("rst_rdata1", rdata1[d], 0);
            chk("rst_rdata2", rdata2[d], 0);
        end
        tick();
        reset = 1'b0;

        // byte-lane merge then read back
        drive(1, 0, 1, 14'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("t1_wr_wait", wait1[0], 0);
        tick();
        drive(1, 0, 1, 14'd5, 32'h00001100, 4'h2);
        tick();
        drive(1, 1, 0, 14'd5, 32'h0, 4'h0);
        tick();
        push(1'b0, 32'hDEAD11EF, cyc, cyc + 1, 1, 1);
        clear(1);
        repeat (3) tick();

        drive(1, 0, 1, 14'd7, 32'hA5A5A5A5, 4'hF); tick();
        drive(1, 0, 1, 14'd1, 32'h11111111, 4'hF); tick();
        clear(1);
        drive(2, 0, 1, 14'd2, 32'h22222222, 4'hF); tick();
        clear(2);
        reset = 1'b1; tick(); reset = 1'b0;

        // alternating grants under continuous contention from reset
        drive(1, 1, 0, 14'd1, 32'h0, 4'h0);
        drive(2, 1, 0, 14'd2, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_s1_wait", wait1[0], (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_s2_wait", wait2[0], (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            if (k % 2 == 0) push(1'b0, 32'h11111111, cyc, cyc + 1, 1, 1);
            else            push(1'b1, 32'h22222222, cyc, cyc + 1, 1, 1);
        end

        // s1 read races s2 write to the same word
        drive(1, 1, 0, 14'd7, 32'h0, 4'h0);
        drive(2, 0, 1, 14'd7, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("t3_s1_wait_a", wait1[0], 0);
        chk("t3_s2_wait_a", wait2[0], 1);
        tick();
        push(1'b0, 32'hA5A5A5A5, cyc, cyc + 1, 1, 1);
        @(negedge clk);
        chk("t3_s1_wait_b", wait1[0], 1);
        chk("t3_s2_wait_b", wait2[0], 0);
        tick();
        clear(2);
        @(negedge clk);
        chk("t3_s1_wait_c", wait1[0], 0);
        tick();
        push(1'b0, 32'h12345678, cyc, cyc + 1, 1, 1);
        clear(1);

        // out-of-range read and write
        drive(1, 1, 0, 14'd10024, 32'h0, 4'h0); tick();
        push(1'b0, 32'h0, cyc, cyc + 1, 1, 1);
        clear(1);
        drive(2, 0, 1, 14'd10030, 32'hFFFFFFFF, 4'hF); tick();
        drive(2, 1, 0, 14'd10030, 32'h0, 4'h0); tick();
        push(1'b1, 32'h0, cyc, cyc + 1, 1, 1);
        clear(2);
        repeat (3) tick();

        // freeze with a read in flight
        drive(1, 1, 0, 14'd1, 32'h0, 4'h0); tick();
        push(1'b0, 32'h11111111, cyc + 3, cyc + 4, 1, 1);
        clear(1);
        clken = 1'b0;
        drive(2, 1, 0, 14'd2, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_s2_wait", wait2[0], 1);
            chk("t5_rdv1_d0", rdv1[0], 0);
            chk("t5_rdv1_d1", rdv1[1], 0);
            tick();
        end
        clken = 1'b1;
        clear(2);
        repeat (4) tick();

        // reset one cycle after accept drops the OUT_REG=1 return
        drive(1, 1, 0, 14'd5, 32'h0, 4'h0); tick();
        push(1'b0, 32'hDEAD11EF, cyc, cyc + 1, 1, 0);
        clear(1);
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_rdv1_d1", rdv1[1], 0);
            tick();
        end
        drive(1, 1, 0, 14'd5, 32'h0, 4'h0);
        drive(2, 1, 0, 14'd7, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_s1_wait", wait1[1], 0);
        chk("t6_s2_wait", wait2[1], 1);
        tick();
        push(1'b0, 32'hDEAD11EF, cyc, cyc + 1, 1, 1);
        clear(1);
        tick();
        push(1'b1, 32'h12345678, cyc, cyc + 1, 1, 1);
        clear(2);
        repeat (5) tick();

        @(negedge clk);
        chk("hold_rdata1_d0", rdata1[0], 32'hDEAD11EF);
        chk("hold_rdata2_d1", rdata2[1], 32'h12345678);
        chk("q0_drained", q[0].size(), 0);
        chk("q1_drained", q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
